// File: rtl/i_cache_assoc.sv
// Two-way set-associative instruction cache with multi-word lines, uncached
// bypass and whole-cache invalidate. Physically tagged by the TLB PFN; refills
// one word at a time over an sram-like bridge with one read outstanding.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | lookup; hits acknowledged combinationally, misses captured
// S_REFILL   | reading the victim line word by word from the bridge
// S_UNCACHED | single bypass read of the captured physical address
// S_DONE     | return the latched requested word to the core
module i_cache_assoc #(
    parameter int INDEX_WIDTH       = 6,
    parameter int WORD_OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,

    input  logic [19:0] inst_pfn,
    input  logic        inst_uncached,
    input  logic        cache_flush,

    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);

    localparam int SETS   = 1 << INDEX_WIDTH;
    localparam int WORDS  = 1 << WORD_OFFSET_WIDTH;
    localparam int SET_LO = WORD_OFFSET_WIDTH + 2;
    localparam int SET_HI = INDEX_WIDTH + WORD_OFFSET_WIDTH + 1;
    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_UNCACHED, S_DONE} state_t;

    state_t state, state_nx;

    logic [SETS-1:0] valid_q [2];
    logic [SETS-1:0] lru_q;
    logic [19:0]     tag_q   [2][SETS];
    logic [31:0]     data_q  [2][SETS][WORDS];

    logic [31:0]                  paddr_q;
    logic                         victim_q;
    logic [WORD_OFFSET_WIDTH-1:0] cnt_q;
    logic                         addr_rcv;
    logic [31:0]                  line_buf [WORDS];
    logic [31:0]                  result_q;

    // the core never writes; these inputs and the high virtual bits are unused
    logic unused_inputs;
    assign unused_inputs = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata,
                             cpu_inst_addr[31:12], cpu_inst_addr[1:0]};

    logic [INDEX_WIDTH-1:0]       req_set;
    logic [WORD_OFFSET_WIDTH-1:0] req_word;
    logic [31:0]                  req_paddr;
    logic [INDEX_WIDTH-1:0]       set_q;
    logic [WORD_OFFSET_WIDTH-1:0] word_q;

    assign req_set   = cpu_inst_addr[SET_HI:SET_LO];
    assign req_word  = cpu_inst_addr[SET_LO-1:2];
    assign req_paddr = {inst_pfn, cpu_inst_addr[11:0]};
    assign set_q     = paddr_q[SET_HI:SET_LO];
    assign word_q    = paddr_q[SET_LO-1:2];

    logic lookup, hit0, hit1, hit, start_fill, start_unc, victim_nx;
    logic bridge_data, fill_last;

    assign lookup     = (state == S_IDLE) && cpu_inst_req && !inst_uncached && !cache_flush;
    assign hit0       = valid_q[0][req_set] && (tag_q[0][req_set] == inst_pfn);
    assign hit1       = valid_q[1][req_set] && (tag_q[1][req_set] == inst_pfn);
    assign hit        = lookup && (hit0 || hit1);
    assign start_fill = lookup && !(hit0 || hit1);
    assign start_unc  = (state == S_IDLE) && cpu_inst_req && inst_uncached && !cache_flush;
    assign victim_nx  = !valid_q[0][req_set] ? 1'b0 :
                        !valid_q[1][req_set] ? 1'b1 : lru_q[req_set];
    // data_ok only counts for a read whose address was already accepted
    assign bridge_data = cache_inst_data_ok && addr_rcv;
    assign fill_last   = (state == S_REFILL) && bridge_data && (cnt_q == LAST_WORD);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // next-state and core/bridge outputs
    always_comb begin
        state_nx         = state;
        cpu_inst_rdata   = 32'h0;
        cpu_inst_addr_ok = 1'b0;
        cpu_inst_data_ok = 1'b0;
        cache_inst_req   = 1'b0;
        cache_inst_addr  = 32'h0;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    cpu_inst_addr_ok = 1'b1;
                    cpu_inst_data_ok = 1'b1;
                    cpu_inst_rdata   = hit0 ? data_q[0][req_set][req_word]
                                            : data_q[1][req_set][req_word];
                end
                if (start_unc)       state_nx = S_UNCACHED;
                else if (start_fill) state_nx = S_REFILL;
            end
            S_REFILL: begin
                cache_inst_req  = !addr_rcv;
                cache_inst_addr = {paddr_q[31:SET_LO], cnt_q, 2'b00};
                if (fill_last) state_nx = S_DONE;
            end
            S_UNCACHED: begin
                cache_inst_req  = !addr_rcv;
                cache_inst_addr = paddr_q;
                if (bridge_data) state_nx = S_DONE;
            end
            S_DONE: begin
                cpu_inst_addr_ok = 1'b1;
                cpu_inst_data_ok = 1'b1;
                cpu_inst_rdata   = result_q;
                state_nx         = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = 2'b10;
    assign cache_inst_wdata = 32'h0;

    // miss capture, refill counter and bridge handshake tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paddr_q  <= 32'h0;
            victim_q <= 1'b0;
            cnt_q    <= '0;
            addr_rcv <= 1'b0;
        end else begin
            if (start_fill || start_unc) begin
                paddr_q  <= req_paddr;
                victim_q <= victim_nx;
                cnt_q    <= '0;
            end
            if (cache_inst_req && cache_inst_addr_ok) addr_rcv <= 1'b1;
            else if (bridge_data)                     addr_rcv <= 1'b0;
            if ((state == S_REFILL) && bridge_data) cnt_q <= cnt_q + 1'b1;
        end
    end

    // valid and LRU bits: flush, refill allocate, hit touch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            if ((state == S_IDLE) && cache_flush) begin
                valid_q[0] <= '0;
                valid_q[1] <= '0;
            end
            if (hit) lru_q[req_set] <= hit0;
            if (fill_last) begin
                valid_q[victim_q][set_q] <= 1'b1;
                lru_q[set_q]             <= ~victim_q;
            end
        end
    end

    // line buffer, returned word, and tag/data arrays (no reset needed)
    always_ff @(posedge clk) begin
        if ((state == S_REFILL) && bridge_data) begin
            line_buf[cnt_q] <= cache_inst_rdata;
            if (cnt_q == word_q) result_q <= cache_inst_rdata;
        end
        if ((state == S_UNCACHED) && bridge_data) result_q <= cache_inst_rdata;
        if (fill_last) begin
            tag_q[victim_q][set_q] <= paddr_q[31:12];
            for (int i = 0; i < WORDS; i++)
                data_q[victim_q][set_q][i] <= line_buf[i];
            // the last word arrives straight from the bridge, not the buffer
            data_q[victim_q][set_q][LAST_WORD] <= cache_inst_rdata;
        end
    end

endmodule

// File: tb/tb_i_cache_assoc.sv
// Directed bench for i_cache_assoc: behavioural bridge with programmable
// addr_ok/data_ok stalls, and a linear sequence of checked accesses.
module tb_i_cache_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_inst_req, cpu_inst_wr;
    logic [1:0]  cpu_inst_size;
    logic [31:0] cpu_inst_addr, cpu_inst_wdata, cpu_inst_rdata;
    logic        cpu_inst_addr_ok, cpu_inst_data_ok;
    logic [19:0] inst_pfn;
    logic        inst_uncached, cache_flush;
    logic        cache_inst_req, cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr, cache_inst_wdata;
    logic [31:0] cache_inst_rdata   = 32'h0;
    logic        cache_inst_addr_ok = 1'b0;
    logic        cache_inst_data_ok = 1'b0;

    i_cache_assoc dut (
        .clk(clk), .rst(rst),
        .cpu_inst_req(cpu_inst_req), .cpu_inst_wr(cpu_inst_wr),
        .cpu_inst_size(cpu_inst_size), .cpu_inst_addr(cpu_inst_addr),
        .cpu_inst_wdata(cpu_inst_wdata), .cpu_inst_rdata(cpu_inst_rdata),
        .cpu_inst_addr_ok(cpu_inst_addr_ok), .cpu_inst_data_ok(cpu_inst_data_ok),
        .inst_pfn(inst_pfn), .inst_uncached(inst_uncached), .cache_flush(cache_flush),
        .cache_inst_req(cache_inst_req), .cache_inst_wr(cache_inst_wr),
        .cache_inst_size(cache_inst_size), .cache_inst_addr(cache_inst_addr),
        .cache_inst_wdata(cache_inst_wdata), .cache_inst_rdata(cache_inst_rdata),
        .cache_inst_addr_ok(cache_inst_addr_ok), .cache_inst_data_ok(cache_inst_data_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // bridge model state
    int          a_dly = 0;
    int          d_dly = 0;
    int          br_phase = 0;
    int          br_cnt = 0;
    logic [31:0] br_cur = 32'h0;
    int          n_reads = 0;
    int          n_data = 0;
    int          viol = 0;
    logic [31:0] addr_log [256];

    // backing memory: pfn 0x1FC00 word k of the page returns 0x10+k
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [19:0] hi;
        hi = a[31:12] ^ 20'h1FC00;
        return {hi[15:0], 16'h0} + {22'h0, a[11:2]} + 32'h10;
    endfunction

    // bridge responds on the falling edge; one read outstanding
    always @(negedge clk) begin
        cache_inst_addr_ok = 1'b0;
        cache_inst_data_ok = 1'b0;
        if (!rst) begin
            br_phase = 0;
            br_cnt   = 0;
        end else if (br_phase == 1) begin
            if (cache_inst_req) viol++;
            if (br_cnt == d_dly) begin
                cache_inst_data_ok = 1'b1;
                cache_inst_rdata   = mem_word(br_cur);
                n_data++;
                br_phase = 2;
                br_cnt   = 0;
            end else br_cnt++;
        end else begin
            br_phase = 0;
            if (cache_inst_req) begin
                if (br_cnt == a_dly) begin
                    cache_inst_addr_ok = 1'b1;
                    br_cur = cache_inst_addr;
                    if (n_reads < 256) addr_log[n_reads] = cache_inst_addr;
                    n_reads++;
                    br_phase = 1;
                    br_cnt   = 0;
                end else br_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive a request starting now (just after a rising edge); lat = cycles to ack
    task automatic access(input logic [31:0] va, input logic [19:0] pfn, input logic unc,
                          output logic [31:0] data, output int lat);
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = va;
        inst_pfn      = pfn;
        inst_uncached = unc;
        lat  = -1;
        data = 32'h0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cpu_inst_addr_ok) begin
                lat  = c;
                data = cpu_inst_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_inst_req  = 1'b0;
        inst_uncached = 1'b0;
    endtask

    logic [31:0] d;
    int          lat;
    int          base;
    int          waited;

    initial begin
        rst = 1'b0;
        cpu_inst_req = 1'b0; cpu_inst_wr = 1'b0; cpu_inst_size = 2'b10;
        cpu_inst_addr = 32'h0; cpu_inst_wdata = 32'h0;
        inst_pfn = 20'h0; inst_uncached = 1'b0; cache_flush = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok",  {31'h0, cpu_inst_addr_ok}, 32'h0);
        chk("rst_data_ok",  {31'h0, cpu_inst_data_ok}, 32'h0);
        chk("rst_br_req",   {31'h0, cache_inst_req},   32'h0);
        chk("rst_br_wr",    {31'h0, cache_inst_wr},    32'h0);
        chk("rst_br_size",  {30'h0, cache_inst_size},  32'h2);
        chk("rst_br_wdata", cache_inst_wdata,          32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // cold miss: req words 0..3 in cycles 1,3,5,7, data in 2,4,6,8, ack in 9
        base = n_reads;
        access(32'hBFC00004, 20'h1FC00, 1'b0, d, lat);
        chk("cold_lat",   32'(lat), 32'd9);
        chk("cold_data",  d, 32'h11);
        chk("cold_reads", 32'(n_reads - base), 32'd4);
        chk("cold_a0", addr_log[base],   32'h1FC00000);
        chk("cold_a1", addr_log[base+1], 32'h1FC00004);
        chk("cold_a2", addr_log[base+2], 32'h1FC00008);
        chk("cold_a3", addr_log[base+3], 32'h1FC0000C);
        access(32'hBFC00008, 20'h1FC00, 1'b0, d, lat);
        chk("hit2_lat", 32'(lat), 32'd0);
        chk("hit2_data", d, 32'h12);
        access(32'hBFC0000C, 20'h1FC00, 1'b0, d, lat);
        chk("hit3_lat", 32'(lat), 32'd0);
        chk("hit3_data", d, 32'h13);

        // uncached bypass, then the same address cached must miss
        base = n_reads;
        access(32'hA0000010, 20'h00000, 1'b1, d, lat);
        chk("unc_lat",   32'(lat), 32'd3);
        chk("unc_data",  d, 32'hFC000014);
        chk("unc_reads", 32'(n_reads - base), 32'd1);
        chk("unc_addr",  addr_log[base], 32'h00000010);
        access(32'hA0000010, 20'h00000, 1'b0, d, lat);
        chk("unc_then_cached_lat", 32'(lat), 32'd9);
        chk("unc_then_cached_data", d, 32'hFC000014);

        // LRU: A, B, A(hit), C evicts B
        access(32'h80000024, 20'h1FC00, 1'b0, d, lat);
        chk("lru_a_lat", 32'(lat), 32'd9);
        access(32'h80000024, 20'h1FC01, 1'b0, d, lat);
        chk("lru_b_lat", 32'(lat), 32'd9);
        chk("lru_b_data", d, 32'h00010019);
        access(32'h80000024, 20'h1FC00, 1'b0, d, lat);
        chk("lru_a_hit_lat", 32'(lat), 32'd0);
        chk("lru_a_hit_data", d, 32'h19);
        access(32'h80000024, 20'h1FC02, 1'b0, d, lat);
        chk("lru_c_lat", 32'(lat), 32'd9);
        chk("lru_c_data", d, 32'h00020019);
        access(32'h80000024, 20'h1FC00, 1'b0, d, lat);
        chk("lru_a_kept_lat", 32'(lat), 32'd0);
        access(32'h80000024, 20'h1FC01, 1'b0, d, lat);
        chk("lru_b_evicted_lat", 32'(lat), 32'd9);
        chk("lru_b_evicted_data", d, 32'h00010019);

        // flush with a request held on the warm line
        cpu_inst_req = 1'b1; cpu_inst_addr = 32'hBFC00004; inst_pfn = 20'h1FC00;
        cache_flush = 1'b1;
        @(negedge clk);
        chk("flush_no_ack", {31'h0, cpu_inst_addr_ok}, 32'h0);
        @(posedge clk); #1 cache_flush = 1'b0;
        access(32'hBFC00004, 20'h1FC00, 1'b0, d, lat);
        chk("flush_refill_lat", 32'(lat), 32'd9);
        chk("flush_refill_data", d, 32'h11);

        // stalled bridge: 10 cycles per word, last data in cycle 40, ack in 41
        a_dly = 3; d_dly = 5;
        access(32'h80000044, 20'h12345, 1'b0, d, lat);
        a_dly = 0; d_dly = 0;
        chk("stall_lat",  32'(lat), 32'd41);
        chk("stall_data", d, 32'hDF450021);
        access(32'h80000040, 20'h12345, 1'b0, d, lat);
        chk("stall_w0_lat", 32'(lat), 32'd0);
        chk("stall_w0_data", d, 32'hDF450020);
        access(32'h8000004C, 20'h12345, 1'b0, d, lat);
        chk("stall_w3_lat", 32'(lat), 32'd0);
        chk("stall_w3_data", d, 32'hDF450023);
        chk("req_while_outstanding", 32'(viol), 32'd0);
        access(32'h80000044, 20'h12346, 1'b0, d, lat);
        chk("tag_mismatch_lat", 32'(lat), 32'd9);
        chk("tag_mismatch_data", d, 32'hDF460021);

        // reset in the middle of a refill, right after word 1 returns
        base = n_data;
        cpu_inst_req = 1'b1; cpu_inst_addr = 32'h80000084; inst_pfn = 20'h1FC00;
        waited = 0;
        while ((n_data - base) < 2 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_reached_w1", 32'(n_data - base), 32'd2);
        @(posedge clk); #1;
        rst = 1'b0; cpu_inst_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_br_req",  {31'h0, cache_inst_req}, 32'h0);
        chk("rst_mid_br_addr", cache_inst_addr, 32'h0);
        chk("rst_mid_ack",     {31'h0, cpu_inst_addr_ok}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        base = n_reads;
        access(32'h80000084, 20'h1FC00, 1'b0, d, lat);
        chk("rst_refill_lat",  32'(lat), 32'd9);
        chk("rst_refill_a0",   addr_log[base], 32'h1FC00080);
        chk("rst_refill_data", d, 32'h31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
